// File: rtl/wbu_pkg.sv
// Shared definitions for the writeback/commit stage.
//   wbu_state_e   : commit FSM states (RUN, FLUSH, HALT)
//   CLS_*         : instruction-class bit ordering shared with EXU
//   FLUSH_CTR_W   : width of the wrong-path drop counter
//   pack_cls      : packs the individual class flags into a class vector
//   is_taken      : taken control transfer decode from a class vector
package wbu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } wbu_state_e;

  localparam int unsigned CLS_BRCH   = 0;
  localparam int unsigned CLS_JAL    = 1;
  localparam int unsigned CLS_JALR   = 2;
  localparam int unsigned CLS_ECALL  = 3;
  localparam int unsigned CLS_MRET   = 4;
  localparam int unsigned CLS_EBREAK = 5;
  localparam int unsigned CLS_W      = 6;

  localparam int unsigned FLUSH_CTR_W = 4;

  function automatic logic [CLS_W-1:0] pack_cls(input logic brch, input logic jal,
                                                input logic jalr, input logic ecall,
                                                input logic mret, input logic ebreak);
    logic [CLS_W-1:0] c;
    c             = '0;
    c[CLS_BRCH]   = brch;
    c[CLS_JAL]    = jal;
    c[CLS_JALR]   = jalr;
    c[CLS_ECALL]  = ecall;
    c[CLS_MRET]   = mret;
    c[CLS_EBREAK] = ebreak;
    return c;
  endfunction

  // Branch taken flag travels in bit 0 of the result.
  function automatic logic is_taken(input logic [CLS_W-1:0] c, input logic res0);
    return c[CLS_JAL] | c[CLS_JALR] | c[CLS_ECALL] | c[CLS_MRET] | (c[CLS_BRCH] & res0);
  endfunction

endpackage

// File: rtl/wbu_flush_ctr.sv
// Loadable 4-bit down-counter timing the wrong-path drop window.
//   clock, reset : clock, asynchronous active-high reset
//   load         : load LOAD_VAL (entry to FLUSH)
//   dec          : decrement by one (while in FLUSH)
//   done         : count has reached 1, i.e. this is the last FLUSH cycle
module wbu_flush_ctr
  import wbu_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam logic [FLUSH_CTR_W-1:0] LOAD_CNT = FLUSH_CTR_W'(LOAD_VAL);

  logic [FLUSH_CTR_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_CNT;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == FLUSH_CTR_W'(1));

endmodule

// File: rtl/wbu_commit.sv
// Writeback/commit stage. Accepts one executed instruction per cycle from
// EXU (i_valid/o_ready), registers GPR and CSR write ports, pulses a PC
// redirect on taken transfers, drops wrong-path instructions for FLUSH_CYC
// cycles, counts retired instructions and halts on ebreak.
//   clock, reset        : clock, asynchronous active-high reset
//   i_valid / o_ready   : EXU handshake; o_ready only in RUN
//   i_pc, i_pc_next     : instruction PC and computed target
//   i_res               : result; bit 0 is the taken flag for branches
//   i_rd_addr, i_wen    : GPR destination and write request
//   i_csr_addr, i_csr_wen : CSR destination and write request
//   i_brch..i_ebreak    : instruction class flags
//   o_rd_*, o_csr_*     : registered write ports (wen is a pulse)
//   o_redirect(_pc)     : one-cycle redirect pulse and target
//   o_retire(_pc)       : one-cycle retire pulse and retired PC
//   o_instret           : retired-instruction count (wraps)
//   o_halted            : sticky after an accepted ebreak
module wbu_commit
  import wbu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RA_W      = 5,
  parameter int unsigned CSR_W     = 12,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_pc_next,
  input  logic [XLEN-1:0]  i_res,
  input  logic [RA_W-1:0]  i_rd_addr,
  input  logic             i_wen,
  input  logic [CSR_W-1:0] i_csr_addr,
  input  logic             i_csr_wen,
  input  logic             i_brch,
  input  logic             i_jal,
  input  logic             i_jalr,
  input  logic             i_ecall,
  input  logic             i_mret,
  input  logic             i_ebreak,
  output logic             o_rd_wen,
  output logic [RA_W-1:0]  o_rd_addr,
  output logic [XLEN-1:0]  o_rd_wdata,
  output logic             o_csr_wen,
  output logic [CSR_W-1:0] o_csr_addr,
  output logic [XLEN-1:0]  o_csr_wdata,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_retire,
  output logic [XLEN-1:0]  o_retire_pc,
  output logic [CNT_W-1:0] o_instret,
  output logic             o_halted
);

  wbu_state_e       state;
  logic [CLS_W-1:0] cls;
  logic             accept;
  logic             taken;
  logic             redirect_go;
  logic             flush_done;

  assign cls         = pack_cls(i_brch, i_jal, i_jalr, i_ecall, i_mret, i_ebreak);
  assign o_ready     = (state == ST_RUN);
  assign accept      = i_valid && o_ready;
  assign taken       = is_taken(cls, i_res[0]);
  // ebreak wins over any redirect in the same instruction.
  assign redirect_go = accept && taken && !cls[CLS_EBREAK];

  wbu_flush_ctr #(
    .LOAD_VAL(FLUSH_CYC)
  ) u_flush_ctr (
    .clock(clock),
    .reset(reset),
    .load (redirect_go),
    .dec  (state == ST_FLUSH),
    .done (flush_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_RUN;
      o_rd_wen      <= 1'b0;
      o_rd_addr     <= '0;
      o_rd_wdata    <= '0;
      o_csr_wen     <= 1'b0;
      o_csr_addr    <= '0;
      o_csr_wdata   <= '0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      o_retire      <= 1'b0;
      o_retire_pc   <= '0;
      o_instret     <= '0;
      o_halted      <= 1'b0;
    end else begin
      o_rd_wen   <= 1'b0;
      o_csr_wen  <= 1'b0;
      o_redirect <= 1'b0;
      o_retire   <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (accept) begin
            o_rd_wen    <= i_wen && (i_rd_addr != '0);
            o_rd_addr   <= i_rd_addr;
            o_rd_wdata  <= i_res;
            o_csr_wen   <= i_csr_wen;
            o_csr_addr  <= i_csr_addr;
            o_csr_wdata <= i_res;
            o_retire    <= 1'b1;
            o_retire_pc <= i_pc;
            o_instret   <= o_instret + CNT_W'(1);
            if (cls[CLS_EBREAK]) begin
              o_halted <= 1'b1;
              state    <= ST_HALT;
            end else if (taken) begin
              o_redirect    <= 1'b1;
              o_redirect_pc <= i_pc_next;
              state         <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_done) state <= ST_RUN;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbu_commit.sv
module tb_wbu_commit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned CSR_W = 12;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned FLUSH = 2;

  // class vector order: {ebreak, mret, ecall, jalr, jal, brch}
  localparam logic [5:0] K_ALU  = 6'b000000;
  localparam logic [5:0] K_BRCH = 6'b000001;
  localparam logic [5:0] K_JAL  = 6'b000010;
  localparam logic [5:0] K_JALR = 6'b000100;
  localparam logic [5:0] K_ECAL = 6'b001000;
  localparam logic [5:0] K_MRET = 6'b010000;
  localparam logic [5:0] K_EBRK = 6'b100000;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [XLEN-1:0]  i_pc = '0, i_pc_next = '0, i_res = '0;
  logic [RA_W-1:0]  i_rd_addr = '0;
  logic             i_wen = 1'b0;
  logic [CSR_W-1:0] i_csr_addr = '0;
  logic             i_csr_wen = 1'b0;
  logic             i_brch = 1'b0, i_jal = 1'b0, i_jalr = 1'b0;
  logic             i_ecall = 1'b0, i_mret = 1'b0, i_ebreak = 1'b0;
  logic             o_rd_wen, o_csr_wen, o_redirect, o_retire, o_halted;
  logic [RA_W-1:0]  o_rd_addr;
  logic [CSR_W-1:0] o_csr_addr;
  logic [XLEN-1:0]  o_rd_wdata, o_csr_wdata, o_redirect_pc, o_retire_pc;
  logic [CNT_W-1:0] o_instret;

  wbu_commit #(
    .XLEN(XLEN), .RA_W(RA_W), .CSR_W(CSR_W), .CNT_W(CNT_W), .FLUSH_CYC(FLUSH)
  ) dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_pc_next(i_pc_next), .i_res(i_res),
    .i_rd_addr(i_rd_addr), .i_wen(i_wen),
    .i_csr_addr(i_csr_addr), .i_csr_wen(i_csr_wen),
    .i_brch(i_brch), .i_jal(i_jal), .i_jalr(i_jalr),
    .i_ecall(i_ecall), .i_mret(i_mret), .i_ebreak(i_ebreak),
    .o_rd_wen(o_rd_wen), .o_rd_addr(o_rd_addr), .o_rd_wdata(o_rd_wdata),
    .o_csr_wen(o_csr_wen), .o_csr_addr(o_csr_addr), .o_csr_wdata(o_csr_wdata),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_retire(o_retire), .o_retire_pc(o_retire_pc),
    .o_instret(o_instret), .o_halted(o_halted)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  // Reference model: a halted flag, a count of cycles left in which input is
  // dropped, and the retired count modulo 2^CNT_W.
  bit          m_halted;
  int unsigned m_block;
  int unsigned m_instret;
  int unsigned seen_ready_low;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pcn,
                       input logic [XLEN-1:0] res, input logic [RA_W-1:0] rd, input logic wen,
                       input logic [CSR_W-1:0] ca, input logic cwen, input logic [5:0] k);
    i_valid = v; i_pc = pc; i_pc_next = pcn; i_res = res;
    i_rd_addr = rd; i_wen = wen; i_csr_addr = ca; i_csr_wen = cwen;
    {i_ebreak, i_mret, i_ecall, i_jalr, i_jal, i_brch} = k;
  endtask

  task automatic model_clear();
    m_halted = 0; m_block = 0; m_instret = 0;
  endtask

  // One clock with the currently driven inputs, then check every output.
  task automatic cyc();
    bit acc, tk;
    bit e_rd_wen, e_csr_wen, e_redir, e_ret;
    acc = i_valid && !m_halted && (m_block == 0);
    tk  = i_jal | i_jalr | i_ecall | i_mret | (i_brch & i_res[0]);
    chk("ready", o_ready, 64'(!m_halted && m_block == 0));
    if (!o_ready) seen_ready_low++;
    @(posedge clock); #1;
    if (m_block > 0) m_block--;
    e_rd_wen = 0; e_csr_wen = 0; e_redir = 0; e_ret = 0;
    if (acc) begin
      e_ret     = 1;
      e_rd_wen  = i_wen && (i_rd_addr != 0);
      e_csr_wen = i_csr_wen;
      m_instret = (m_instret + 1) % (1 << CNT_W);
      if (i_ebreak) m_halted = 1;
      else if (tk) begin
        e_redir = 1;
        m_block = FLUSH;
      end
    end
    chk("rd_wen", o_rd_wen, 64'(e_rd_wen));
    chk("csr_wen", o_csr_wen, 64'(e_csr_wen));
    chk("redirect", o_redirect, 64'(e_redir));
    chk("retire", o_retire, 64'(e_ret));
    chk("instret", o_instret, 64'(m_instret));
    chk("halted", o_halted, 64'(m_halted));
    if (e_rd_wen) begin
      chk("rd_addr", o_rd_addr, 64'(i_rd_addr));
      chk("rd_wdata", o_rd_wdata, 64'(i_res));
    end
    if (e_csr_wen) begin
      chk("csr_addr", o_csr_addr, 64'(i_csr_addr));
      chk("csr_wdata", o_csr_wdata, 64'(i_res));
    end
    if (e_redir) chk("redirect_pc", o_redirect_pc, 64'(i_pc_next));
    if (e_ret) chk("retire_pc", o_retire_pc, 64'(i_pc));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, o_ready, 64'(1));
    chk({tag, "_rd_wen"}, o_rd_wen, 0);
    chk({tag, "_rd_wdata"}, o_rd_wdata, 0);
    chk({tag, "_csr_wen"}, o_csr_wen, 0);
    chk({tag, "_csr_addr"}, o_csr_addr, 0);
    chk({tag, "_redirect"}, o_redirect, 0);
    chk({tag, "_redirect_pc"}, o_redirect_pc, 0);
    chk({tag, "_retire"}, o_retire, 0);
    chk({tag, "_instret"}, o_instret, 0);
    chk({tag, "_halted"}, o_halted, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, K_ALU);
    reset = 1'b1;
    #1;
    model_clear();
    check_reset_state("rst");
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [XLEN-1:0] pc;
    do_reset();

    // Back-to-back ALU ops, rd 1, 2, 0; ready must stay high throughout.
    seen_ready_low = 0;
    drive(1, 32'h100, 32'h104, 32'h11, 5'd1, 1, 0, 0, K_ALU); cyc();
    drive(1, 32'h104, 32'h108, 32'h22, 5'd2, 1, 0, 0, K_ALU); cyc();
    drive(1, 32'h108, 32'h10c, 32'h33, 5'd0, 1, 0, 0, K_ALU); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, K_ALU); cyc();
    chk("alu_instret3", o_instret, 64'd3);
    chk("alu_ready_never_low", 64'(seen_ready_low), 0);

    // Taken jal, then continuous valids: two dropped, third accepted.
    drive(1, 32'h200, 32'h8000_0100, 32'h204, 5'd1, 1, 0, 0, K_JAL); cyc();
    chk("jal_redirect_pc", o_redirect_pc, 64'h8000_0100);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h8000_0100 + 32'(4 * i), 0, 32'(i), 5'd3, 1, 0, 0, K_ALU);
      cyc();
    end
    chk("jal_instret", o_instret, 64'd6);

    // Branch not taken then taken.
    drive(1, 32'h300, 32'h400, 32'h0, 5'd0, 0, 0, 0, K_BRCH); cyc();
    drive(1, 32'h304, 32'h500, 32'h1, 5'd0, 0, 0, 0, K_BRCH); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, K_ALU);
    for (int i = 0; i < 3; i++) cyc();

    // csrrw to mtvec.
    drive(1, 32'h600, 32'h604, 32'h8000_0000, 5'd0, 0, 12'h305, 1, K_ALU); cyc();
    chk("csr_addr_305", o_csr_addr, 64'h305);
    drive(0, 0, 0, 0, 0, 0, 0, 0, K_ALU); cyc();

    // Other taken classes.
    drive(1, 32'h700, 32'h900, 0, 5'd1, 1, 0, 0, K_JALR); cyc();
    drive(1, 32'h704, 32'h904, 0, 5'd1, 1, 0, 0, K_ECAL); cyc(); cyc();
    drive(1, 32'h900, 32'h980, 0, 5'd0, 0, 0, 0, K_MRET); cyc(); cyc(); cyc();

    // Counter wrap: 17 retires with a 4-bit counter leaves 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 32'(32'h1000 + 4 * i), 0, 32'(i), 5'(i), 1, 0, 0, K_ALU);
      cyc();
    end
    chk("wrap_instret", o_instret, 64'd1);

    // ebreak with a write, then valids ignored for 20 cycles.
    drive(1, 32'h2000, 32'h2004, 32'hDEAD, 5'd5, 1, 0, 0, K_EBRK); cyc();
    chk("ebrk_wdata", o_rd_wdata, 64'hDEAD);
    chk("ebrk_halted", o_halted, 64'd1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'(32'h2004 + 4 * i), 32'h3000, 32'h1, 5'd7, 1, 12'h300, 1, K_JAL);
      cyc();
    end
    do_reset();
    chk("post_halt_ready", o_ready, 64'd1);
    chk("post_halt_instret", o_instret, 0);

    // csrrw with reset asserted in the same cycle: no pulse.
    drive(1, 32'h40, 32'h44, 32'h8000_0000, 5'd0, 0, 12'h305, 1, K_ALU);
    reset = 1'b1;
    #1;
    model_clear();
    @(posedge clock); #1;
    chk("rst_csr_no_pulse", o_csr_wen, 0);
    chk("rst_csr_no_retire", o_retire, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, K_ALU);
    reset = 1'b0;
    cyc();

    // Randomized traffic against the model; recover from halts by reset.
    pc = 32'h1_0000;
    for (int i = 0; i < 400; i++) begin
      logic [5:0] k;
      int unsigned r;
      r = $urandom_range(0, 39);
      if (r < 20)      k = K_ALU;
      else if (r < 28) k = K_BRCH;
      else if (r < 31) k = K_JAL;
      else if (r < 34) k = K_JALR;
      else if (r < 36) k = K_ECAL;
      else if (r < 38) k = K_MRET;
      else if (r < 39) k = (($urandom_range(0, 3) == 0) ? K_EBRK : K_ALU);
      else             k = K_ALU | K_EBRK | K_JAL;
      drive(1'($urandom_range(0, 3) != 0), pc, $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom), 12'($urandom),
            1'($urandom_range(0, 3) == 0), k);
      cyc();
      pc = pc + 4;
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wbu_commit.md
# wbu_commit

Parametrised writeback/commit stage: the successor to the single-width writeback unit. Accepts one executed instruction per cycle from EXU over a valid/ready handshake and drives registered GPR/CSR write ports. Generates a one-cycle PC-redirect pulse for taken control transfers and discards wrong-path instructions for a programmable number of cycles. Also counts retired instructions and halts on `ebreak`.

## Interface
Parameters:
- `XLEN`, 32: data/PC width.
- `RA_W`, 5: GPR address width.
- `CSR_W`, 12: CSR address width.
- `CNT_W`, 64: retire-counter width.
- `FLUSH_CYC`, 1: wrong-path drop window after a redirect (1..15).

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  EXU result valid.
- `o_ready`  out  1  stage can accept.
- `i_pc`, `i_pc_next`  in  XLEN  instruction PC; computed target.
- `i_res`  in  XLEN  result; bit 0 is the branch-taken flag when `i_brch`.
- `i_rd_addr`  in  RA_W.
- `i_wen`  in  1.
- `i_csr_addr`  in  CSR_W.
- `i_csr_wen`  in  1.
- `i_brch`, `i_jal`, `i_jalr`, `i_ecall`, `i_mret`, `i_ebreak`  in  1 each  instruction class.
- `o_rd_wen`  out  1.
- `o_rd_addr`  out  RA_W.
- `o_rd_wdata`  out  XLEN.
- `o_csr_wen`  out  1.
- `o_csr_addr`  out  CSR_W.
- `o_csr_wdata`  out  XLEN.
- `o_redirect`  out  1  one-cycle pulse.
- `o_redirect_pc`  out  XLEN.
- `o_retire`  out  1  one-cycle pulse per committed instruction.
- `o_retire_pc`  out  XLEN.
- `o_instret`  out  CNT_W  retired count.
- `o_halted`  out  1  sticky after `ebreak`.

## Operation
- Accept = `i_valid && o_ready`. `o_ready` = (state == RUN).
- States and transitions:
  - RUN → FLUSH on an accepted taken transfer.
  - RUN → HALT on an accepted `ebreak`.
  - FLUSH → RUN after `FLUSH_CYC` cycles.
  - HALT is left only by reset.
- Taken transfer = `i_jal | i_jalr | i_ecall | i_mret | (i_brch & i_res[0])`.
- On accept, all outputs register in the next cycle:
  - `o_rd_wen = i_wen && i_rd_addr != 0`, with addr/wdata = `i_rd_addr`/`i_res`.
  - `o_csr_wen = i_csr_wen`, `o_csr_wdata = i_res`.
  - `o_retire = 1`, `o_retire_pc = i_pc`.
  - `o_redirect` = taken transfer, with `o_redirect_pc = i_pc_next`.
- Write enables, `o_retire` and `o_redirect` are single-cycle pulses. Address/data outputs hold their last value.
- In FLUSH and HALT, `i_valid` is ignored: no write, no retire, no count.
- `ebreak` with `i_wen` set still performs its write and retires, then halts. `ebreak` takes priority over redirect: no `o_redirect` is issued.
- `o_instret` increments by 1 in the cycle `o_retire` is high and wraps modulo 2^CNT_W.
- A non-taken branch (`i_brch & ~i_res[0]`) retires with no redirect and stays in RUN.

## Timing
- Reset values, all outputs: 0, except `o_ready` = 1. State = RUN.
- Latency: accept in cycle N → write, retire and redirect visible in cycle N+1.
- Throughput: 1 instruction/cycle in RUN.
- After a redirect accepted in cycle N, `o_ready` = 0 in cycles N+1..N+FLUSH_CYC and returns to 1 in cycle N+FLUSH_CYC+1.
- Flush counter: 4 bits, loaded with `FLUSH_CYC` on entry to FLUSH, decremented each cycle, exits at 1.
- `o_halted` rises in N+1 after an accepted `ebreak`. `o_ready` falls in the same cycle.
- Reset asserted mid-FLUSH or mid-HALT returns to RUN immediately and clears the counter and pulses; `o_instret` is cleared too.

## Structure
- Shared package `wbu_pkg`: state enum (RUN, FLUSH, HALT) and the instruction-class bit ordering shared with EXU.
- One sub-module, `wbu_flush_ctr`: the loadable down-counter with done flag.
- Everything else, including the FSM, output registers and instret counter, is flat in `wbu_commit`.

## Test plan
- Back-to-back ALU ops: rd = 1, 2, 0 with data 0x11, 0x22, 0x33.
  - `o_rd_wen` pulses for rd 1 and 2 only.
  - `o_instret` reaches 3.
  - `o_ready` is never low.
- Taken `jal` with `i_pc_next` = 0x8000_0100, FLUSH_CYC = 2, followed by continuous valids:
  - `o_redirect` pulses with 0x8000_0100.
  - The next 2 valids are dropped and `o_instret` does not count them.
  - Acceptance resumes on the 3rd cycle.
- `i_brch` with `i_res` = 0 → retire only, no redirect. With `i_res` = 1 → redirect.
- `ebreak` with `i_wen`, rd = 5, data 0xDEAD:
  - Write occurs and `o_halted` = 1.
  - Further valids are ignored for 20 cycles.
  - Reset restores `o_ready` = 1 and `o_instret` = 0.
- CNT_W = 4: 17 retires → `o_instret` = 1 (wrap).
- `csrrw` (`i_csr_wen`, addr 0x305, `i_res` = 0x8000_0000) → `o_csr_wen` pulse with matching addr and data. Reset asserted in the same cycle → no pulse.
